// File: rtl/modmul_digit_ctrl.sv
// Digit sequencer for the radix-4 interleaved modular multiplier. It scans a private
// copy of B two bits per cycle, MSB first, and frames each operation with first/last/done.
//
// state | meaning
// IDLE  | waiting for start; b is captured on the accepting edge
// RUN   | one radix-4 digit per cycle on sel, D cycles
// FLUSH | sel held at zero while the datapath pipeline drains, LAT cycles
// DONE  | one-cycle completion pulse, then back to IDLE
module modmul_digit_ctrl #(
    parameter int N   = 1 << 16,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic [1:0]   sel,
    output logic         sel_valid,
    output logic         first,
    output logic         last,
    output logic         done
);

    localparam int D  = N / 2;
    localparam int CW = $clog2(D) + 1;
    localparam int FW = $clog2(LAT + 1) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [FW-1:0]  flush_q, flush_d;
    logic           busy_q, busy_d;
    logic [1:0]     sel_q, sel_d;
    logic           sel_valid_q, sel_valid_d;
    logic           first_q, first_d;
    logic           last_q, last_d;
    logic           done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            flush_q     <= '0;
            busy_q      <= 1'b0;
            sel_q       <= 2'b00;
            sel_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            busy_q      <= busy_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            first_q     <= first_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    shreg_d = b;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                shreg_d = {shreg_q[N-3:0], 2'b00};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(D - 1)) begin
                    if (LAT > 0) begin
                        state_d = FLUSH;
                        flush_d = FW'(LAT);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FLUSH: begin
                // Down-counter loaded with LAT; terminal count at 1 gives exactly LAT cycles.
                if (flush_q == FW'(1)) begin
                    state_d = DONE;
                end else begin
                    flush_d = flush_q - FW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that every output is a flop.
    always_comb begin
        busy_d      = (state_d != IDLE);
        sel_valid_d = (state_d == RUN);
        sel_d       = (state_d == RUN) ? shreg_d[N-1:N-2] : 2'b00;
        first_d     = (state_q == IDLE) && (state_d == RUN);
        last_d      = (state_d == RUN) && (cnt_d == CW'(D - 1));
        done_d      = (state_d == DONE);
    end

    assign busy      = busy_q;
    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign first     = first_q;
    assign last      = last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_modmul_digit_ctrl.sv
// Scoreboard bench for modmul_digit_ctrl: three instances (N=8/LAT=2, N=8/LAT=0, N=16/LAT=3)
// exercised one at a time with directed operands; a negedge monitor checks every output.
module tb_modmul_digit_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_w = 3'b000;
    logic [7:0]  b0 = 8'h00;
    logic [7:0]  b1 = 8'h00;
    logic [15:0] b2 = 16'h0000;

    logic [2:0]  busy_w, sv_w, first_w, last_w, done_w;
    logic [1:0]  sel_w [3];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    int nd  [3] = '{4, 4, 8};
    int lat [3] = '{2, 0, 3};

    typedef struct {
        int         inst;
        int         cyc;
        logic [1:0] sel;
        logic       first;
        logic       last;
    } dig_t;

    typedef struct {
        int inst;
        int cyc;
    } done_t;

    typedef struct {
        int inst;
        int lo;
        int hi;
    } win_t;

    dig_t  dq[$];
    done_t doneq[$];
    win_t  wq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    modmul_digit_ctrl #(.N(8), .LAT(2)) u0 (
        .clk(clk), .rst(rst), .start(start_w[0]), .b(b0),
        .busy(busy_w[0]), .sel(sel_w[0]), .sel_valid(sv_w[0]),
        .first(first_w[0]), .last(last_w[0]), .done(done_w[0])
    );

    modmul_digit_ctrl #(.N(8), .LAT(0)) u1 (
        .clk(clk), .rst(rst), .start(start_w[1]), .b(b1),
        .busy(busy_w[1]), .sel(sel_w[1]), .sel_valid(sv_w[1]),
        .first(first_w[1]), .last(last_w[1]), .done(done_w[1])
    );

    modmul_digit_ctrl #(.N(16), .LAT(3)) u2 (
        .clk(clk), .rst(rst), .start(start_w[2]), .b(b2),
        .busy(busy_w[2]), .sel(sel_w[2]), .sel_valid(sv_w[2]),
        .first(first_w[2]), .last(last_w[2]), .done(done_w[2])
    );

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a digit or a done pulse.
    always @(negedge clk) begin
        bit    eb;
        dig_t  e;
        done_t dn;
        for (int i = 0; i < 3; i++) begin
            eb = 1'b0;
            foreach (wq[k]) begin
                if (wq[k].inst == i && cyc >= wq[k].lo && cyc <= wq[k].hi) eb = 1'b1;
            end
            check(busy_w[i] == eb, "busy", int'(busy_w[i]), int'(eb));

            if (sv_w[i]) begin
                if (dq.size() == 0 || dq[0].inst != i) begin
                    check(1'b0, "unexpected_digit", i, -1);
                end else begin
                    e = dq.pop_front();
                    check(cyc == e.cyc, "digit_cycle", cyc, e.cyc);
                    check(sel_w[i] == e.sel, "sel", int'(sel_w[i]), int'(e.sel));
                    check(first_w[i] == e.first, "first", int'(first_w[i]), int'(e.first));
                    check(last_w[i] == e.last, "last", int'(last_w[i]), int'(e.last));
                end
            end else begin
                check(sel_w[i] == 2'b00 && !first_w[i] && !last_w[i], "quiet_sel",
                      int'({sel_w[i], first_w[i], last_w[i]}), 0);
            end

            if (done_w[i]) begin
                if (doneq.size() == 0 || doneq[0].inst != i) begin
                    check(1'b0, "unexpected_done", i, -1);
                end else begin
                    dn = doneq.pop_front();
                    check(cyc == dn.cyc, "done_cycle", cyc, dn.cyc);
                end
            end
        end
    end

    task automatic push_op(input int i, input int a, input logic [15:0] bv);
        int   d;
        dig_t e;
        d = nd[i];
        for (int j = 0; j < d; j++) begin
            e.inst  = i;
            e.cyc   = a + j;
            e.sel   = bv[(2*d - 1 - 2*j) -: 2];
            e.first = (j == 0);
            e.last  = (j == d - 1);
            dq.push_back(e);
        end
        doneq.push_back('{i, a + d + lat[i]});
        wq.push_back('{i, a, a + d + lat[i]});
    endtask

    task automatic drive_b(input int i, input logic [15:0] bv);
        if (i == 0) b0 = bv[7:0];
        else if (i == 1) b1 = bv[7:0];
        else b2 = bv;
    endtask

    task automatic issue(input int i, input logic [15:0] bv, output int a);
        @(negedge clk);
        drive_b(i, bv);
        start_w[i] = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        start_w[i] = 1'b0;
        push_op(i, a, bv);
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (dq.size() == 0 && doneq.size() == 0) break;
        end
        check(dq.size() == 0 && doneq.size() == 0, "drain_timeout", dq.size() + doneq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int a;
        int a2;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic sequence, LAT=2: sel 3,1,2,0 then two flush cycles then done.
        issue(0, 16'h00D8, a);
        drain();

        // LAT=0: straight from the last digit to done.
        issue(1, 16'h00FF, a);
        drain();

        // start held high: second accept only in the first IDLE cycle after DONE.
        @(negedge clk);
        b0 = 8'h1B;
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        push_op(0, a, 16'h001B);
        a2 = a + nd[0] + lat[0] + 2;
        for (int t = 0; t < 20; t++) begin
            if (cyc >= a2) break;
            @(posedge clk);
            #1;
        end
        check(cyc == a2, "hold_accept_cycle", cyc, a2);
        push_op(0, a2, 16'h001B);
        @(negedge clk);
        start_w[0] = 1'b0;
        drain();

        // b changes during RUN must not disturb the captured copy.
        issue(0, 16'h00A5, a);
        b0 = 8'h00;
        drain();

        // Asynchronous reset in the third RUN cycle abandons the operation.
        issue(0, 16'h00D8, a);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check(busy_w[0] == 1'b0, "rst_busy", int'(busy_w[0]), 0);
        check(sel_w[0] == 2'b00, "rst_sel", int'(sel_w[0]), 0);
        check(sv_w[0] == 1'b0, "rst_sel_valid", int'(sv_w[0]), 0);
        check(last_w[0] == 1'b0, "rst_last", int'(last_w[0]), 0);
        check(done_w[0] == 1'b0, "rst_done", int'(done_w[0]), 0);
        dq.delete();
        doneq.delete();
        wq.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        issue(0, 16'h00D8, a);
        drain();

        // N=16, LAT=3: single set bits at both ends of the operand.
        issue(2, 16'h8001, a);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
